// File: rtl/divider_8x4_seq.sv
// Sequential restoring divider: DIVIDEND_W-bit unsigned dividend / DIVISOR_W-bit unsigned divisor, one quotient bit per clock.
// Optional macro DIV_EARLY_EXIT_EN: divisor==1 and dividend<divisor finish without iterating (same numeric results).
module divider_8x4_seq #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam int REM_W = DIVISOR_W + 1;
  localparam logic [CNT_W-1:0]      CNT_LAST     = CNT_W'(DIVIDEND_W - 1);
  localparam logic [CNT_W-1:0]      CNT_ZERO     = {CNT_W{1'b0}};
  localparam logic [DIVISOR_W-1:0]  DIVISOR_ZERO = {DIVISOR_W{1'b0}};
  localparam logic [DIVIDEND_W-1:0] SHIFT_ONES   = {DIVIDEND_W{1'b1}};
  localparam logic [DIVIDEND_W-1:0] SHIFT_ZERO   = {DIVIDEND_W{1'b0}};
`ifdef DIV_EARLY_EXIT_EN
  localparam logic [DIVISOR_W-1:0]  DIVISOR_ONE  = DIVISOR_W'(1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_r;
  state_t                state_nxt_s;
  logic                  accept_s;
  logic                  short_s;
  logic [CNT_W-1:0]      cnt_r;
  // A restored remainder is always below the divisor, so only the trial value needs the extra bit.
  logic [DIVISOR_W-1:0]  rem_r;
  logic [DIVIDEND_W-1:0] shift_r;
  logic [DIVISOR_W-1:0]  divisor_r;
  logic [REM_W-1:0]      step_t_s;
  logic [DIVISOR_W-1:0]  step_rem_s;
  logic                  step_bit_s;
  logic                  busy_r;
  logic                  done_r;
  logic [DIVIDEND_W-1:0] quotient_r;
  logic [DIVISOR_W-1:0]  remainder_r;
  logic                  dbz_r;

  // Next-state decode and start acceptance (only while not busy)
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    short_s     = (divisor == DIVISOR_ZERO);
`ifdef DIV_EARLY_EXIT_EN
    if ((divisor == DIVISOR_ONE) ||
        (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor})) begin
      short_s = 1'b1;
    end else begin
      short_s = (divisor == DIVISOR_ZERO);
    end
`endif
    case (state_r)
      IDLE, DONE: begin
        if (start && !busy_r) begin
          accept_s    = 1'b1;
          state_nxt_s = short_s ? DONE : RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // One restoring step: shift in the next dividend bit, subtract when it fits
  always_comb begin
    step_t_s = {rem_r, shift_r[DIVIDEND_W-1]};
    if (step_t_s >= {1'b0, divisor_r}) begin
      step_rem_s = DIVISOR_W'(step_t_s - {1'b0, divisor_r});
      step_bit_s = 1'b1;
    end else begin
      step_rem_s = step_t_s[DIVISOR_W-1:0];
      step_bit_s = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Working registers, iteration counter and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r       <= CNT_ZERO;
      rem_r       <= DIVISOR_ZERO;
      shift_r     <= SHIFT_ZERO;
      divisor_r   <= DIVISOR_ZERO;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      quotient_r  <= SHIFT_ZERO;
      remainder_r <= DIVISOR_ZERO;
      dbz_r       <= 1'b0;
    end else begin
      done_r <= (state_r == DONE);
      busy_r <= accept_s || ((state_r == RUN) && (cnt_r != CNT_ZERO));
      if (state_r == DONE) begin
        quotient_r  <= shift_r;
        remainder_r <= rem_r;
        dbz_r       <= (divisor_r == DIVISOR_ZERO);
      end
      if (accept_s) begin
        divisor_r <= divisor;
        cnt_r     <= CNT_LAST;
        // Short paths preload the final result so DONE handles every case the same way
        if (divisor == DIVISOR_ZERO) begin
          shift_r <= SHIFT_ONES;
          rem_r   <= DIVISOR_ZERO;
`ifdef DIV_EARLY_EXIT_EN
        end else if (divisor == DIVISOR_ONE) begin
          shift_r <= dividend;
          rem_r   <= DIVISOR_ZERO;
        end else if (dividend < {{(DIVIDEND_W-DIVISOR_W){1'b0}}, divisor}) begin
          shift_r <= SHIFT_ZERO;
          rem_r   <= dividend[DIVISOR_W-1:0];
`endif
        end else begin
          shift_r <= dividend;
          rem_r   <= DIVISOR_ZERO;
        end
      end else if (state_r == RUN) begin
        shift_r <= {shift_r[DIVIDEND_W-2:0], step_bit_s};
        rem_r   <= step_rem_s;
        if (cnt_r != CNT_ZERO) begin
          cnt_r <= cnt_r - CNT_W'(1);
        end
      end
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign div_by_zero = dbz_r;

endmodule

// File: doc/divider_8x4_seq.md
Name: divider_8x4_seq

Overview:
- Sequential restoring divider; the arithmetic inverse of the team's 4x4 array multiplier.
- Computes quotient and remainder of an 8-bit unsigned dividend by a 4-bit unsigned divisor.
- Produces one quotient bit per clock.
- Sits beside the multiplier in the arithmetic datapath and is driven by a start/done handshake from the control FSM.

Parameters:
- DIVIDEND_W, 8, dividend and quotient width; also the number of iteration cycles.
- DIVISOR_W, 4, divisor and remainder width.

Ports:
- clk  input  1  single system clock; all logic is rising-edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request pulse; sampled only when busy=0.
- dividend  input  DIVIDEND_W  unsigned dividend; captured when start is accepted.
- divisor  input  DIVISOR_W  unsigned divisor; captured when start is accepted.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle onward.
- quotient  output  DIVIDEND_W  registered quotient; held until the next accepted start.
- remainder  output  DIVISOR_W  registered remainder; held until the next accepted start.
- div_by_zero  output  1  set with done when the captured divisor is 0; held until the next accepted start.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE.
  - busy, done, div_by_zero = 0.
  - quotient, remainder = 0.
  - Iteration counter and working registers cleared.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 captures the operands.
  - Working remainder (DIVISOR_W+1 bits) <= 0; shift register <= dividend; counter <= DIVIDEND_W-1.
  - If divisor==0, go to DONE with quotient = all ones, remainder = 0, div_by_zero = 1 (a one-cycle latency to done).
  - Otherwise go to RUN.
- RUN (one restoring step per cycle):
  - t = {rem[DIVISOR_W-1:0], shift MSB}; shift register shifts left.
  - If t >= {1'b0, divisor}: rem <= t - divisor, shift LSB <= 1. Else: rem <= t, shift LSB <= 0.
  - When counter==0, go to DONE; otherwise decrement the counter.
- DONE:
  - done=1 for exactly one cycle.
  - quotient <= shift register; remainder <= rem[DIVISOR_W-1:0].
  - Next state is IDLE, or RUN/DONE if start=1 is accepted in this cycle (back-to-back accepted).
- busy=1 in RUN, and in the cycle after an accepted start in which the next state is DONE. busy=0 in IDLE and DONE.
- Latency: start accepted at edge k gives done high in the cycle after edge k+DIVIDEND_W+1 (9 cycles for the default parameters).
- Start while busy=1 is ignored; operands are not recaptured and the in-flight result is unaffected.
- Operands may change freely after the capture edge.
- Outputs are never X after reset.
- Invariant for non-zero divisor: quotient*divisor + remainder == dividend, and remainder < divisor.

Optional Feature:
- Macro: DIV_EARLY_EXIT_EN.
- Defined:
  - In IDLE, if divisor != 0 and dividend < divisor, skip RUN and go directly to DONE.
  - Result: quotient = 0, remainder = dividend[DIVISOR_W-1:0], done one cycle after start.
  - Also: if divisor==1, go directly to DONE with quotient = dividend, remainder = 0.
- Undefined:
  - These cases take the full DIVIDEND_W-cycle path.
  - Numeric results are identical either way; only latency differs.

Test Plan:
- dividend=200, divisor=7, start pulse -> done after 9 cycles; quotient=28, remainder=4, div_by_zero=0; busy high for 8 cycles.
- dividend=255, divisor=15 -> quotient=17, remainder=0. Then, without idle cycles, start with dividend=255, divisor=1 in the done cycle -> quotient=255, remainder=0 (1 cycle with DIV_EARLY_EXIT_EN, 9 without).
- dividend=5, divisor=0 -> done on the cycle after start; quotient=8'hFF, remainder=0, div_by_zero=1. A following op 9/2 clears the flag: quotient=4, remainder=1.
- dividend=3, divisor=9 -> quotient=0, remainder=3; done after 1 cycle with DIV_EARLY_EXIT_EN, 9 cycles without.
- Start 100/3, then pulse start with 50/5 in RUN cycle 3 -> second request ignored; result quotient=33, remainder=1.
- Start 100/3, assert rst_n=0 in RUN cycle 4 -> no done pulse; all outputs 0 next cycle. A following 17/4 gives quotient=4, remainder=1.
